// File: rtl/flash_read_arbiter_pkg.sv
// Shared definitions for the flash read arbiter and the CPU bus bridge that
// reuses its timing defaults.
package flash_read_arbiter_pkg;

  localparam int READ_WAIT_DEFAULT    = 6;
  localparam int SUCCESS_HOLD_DEFAULT = 2;

  typedef logic [2:0] state_t;
  typedef logic       client_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_READ     = 3'd1;
  localparam state_t ST_VGA_RESP = 3'd2;
  localparam state_t ST_CPU_RESP = 3'd3;
  localparam state_t ST_GAP      = 3'd4;

  localparam client_t GRANT_VGA = 1'b0;
  localparam client_t GRANT_CPU = 1'b1;

endpackage

// File: rtl/flash_rr_arbiter.sv
// Two-requester round-robin grant; last_grant only moves when the grant is
// actually accepted, so an unaccepted offer does not rotate priority.
module flash_rr_arbiter
  import flash_read_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vga_req,
  input  logic cpu_req,
  input  logic accept,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant;

  always_comb begin
    grant_valid = vga_req | cpu_req;
    grant_id    = GRANT_VGA;
    if (vga_req && cpu_req)
      grant_id = (last_grant == GRANT_VGA) ? GRANT_CPU : GRANT_VGA;
    else if (cpu_req)
      grant_id = GRANT_CPU;
  end

  // Reset to CPU so that VGA wins the first contended grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= GRANT_CPU;
    else if (accept && grant_valid)
      last_grant <= grant_id;
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates the VGA loader and CPU read ports onto a 16-bit asynchronous
// NOR flash read cycle with programmable wait states.
module flash_read_arbiter
  import flash_read_arbiter_pkg::*;
#(
  parameter int READ_WAIT    = READ_WAIT_DEFAULT,
  parameter int SUCCESS_HOLD = SUCCESS_HOLD_DEFAULT,
  parameter int ADDR_W       = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_re,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [15:0]       vga_data,
  output logic              vga_success,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [15:0]       cpu_data,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] flash_a,
  input  logic [15:0]       flash_d,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_rp_n,
  output logic              flash_byte_n
);

  localparam int HOLD_W = (SUCCESS_HOLD > 1) ? $clog2(SUCCESS_HOLD) : 1;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              cur_client;
  logic              grant_valid;
  logic              grant_id;
  logic              accept;
  logic [ADDR_W-1:0] req_addr;

  assign flash_we_n   = 1'b1;
  assign flash_rp_n   = 1'b1;
  assign flash_byte_n = 1'b1;

  assign accept   = (state == ST_IDLE) && grant_valid;
  assign req_addr = (grant_id == GRANT_CPU) ? cpu_addr : vga_addr;

  flash_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .vga_req     (vga_re),
    .cpu_req     (cpu_re),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Strobes stay low for READ_WAIT cycles; data is captured on the edge that
  // ends the last one, while the flash is still driving the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
      cur_client  <= GRANT_CPU;
      flash_a     <= '0;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      vga_data    <= '0;
      vga_success <= 1'b0;
      cpu_data    <= '0;
      cpu_ack     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            flash_a    <= req_addr & ~ADDR_W'(1);
            flash_ce_n <= 1'b0;
            flash_oe_n <= 1'b0;
            wait_cnt   <= 4'(READ_WAIT - 1);
            cur_client <= grant_id;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (wait_cnt == 4'd0) begin
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            if (cur_client == GRANT_VGA) begin
              vga_data    <= flash_d;
              vga_success <= 1'b1;
              hold_cnt    <= HOLD_W'(SUCCESS_HOLD - 1);
              state       <= ST_VGA_RESP;
            end else begin
              cpu_data <= flash_d;
              cpu_ack  <= 1'b1;
              state    <= ST_CPU_RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_VGA_RESP: begin
          if (hold_cnt == '0) begin
            vga_success <= 1'b0;
            state       <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        ST_CPU_RESP: begin
          cpu_ack <= 1'b0;
          state   <= ST_GAP;
        end
        // Gives the flash its CE high time and the loader a low success cycle.
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
